pipe_stage_chain: RTL and testbench



---
 rtl/pipe_stage_chain.sv | 131 +++++++++++++
 tb/tb_pipe_stage_chain.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// Purpose: elastic pipeline-register chain (DEPTH stages of WIDTH-bit payload + valid).
// Latency: DEPTH-1 cycles from acceptance into stage 0 to presentation on OutValid; 1 item/cycle.
// Backpressure: OutReady=0 stalls only stages that are full up to the output; bubbles collapse.
//
// Ports:
//   Clk, Rst                  clock, asynchronous active-low reset
//   InValid/InData/InReady    upstream valid/ready handshake into stage 0
//   OutValid/OutData/OutReady downstream valid/ready handshake from stage DEPTH-1
//   Flush                     drop every in-flight item and refuse input this cycle
//   KillMask                  bit i drops the item currently in stage i
//   Occupancy                 registered count of valid stages
//   StallCnt                  saturating count of cycles with OutValid=1 and OutReady=0
//
// Optional feature macro: PIPE_STALL_CNT_EN. When undefined StallCnt is tied to 0.

module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       InValid,
  input  logic [WIDTH-1:0]           InData,
  output logic                       InReady,
  output logic                       OutValid,
  output logic [WIDTH-1:0]           OutData,
  input  logic                       OutReady,
  input  logic                       Flush,
  input  logic [DEPTH-1:0]           KillMask,
  output logic [$clog2(DEPTH+1)-1:0] Occupancy,
  output logic [CNT_W-1:0]           StallCnt
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] rdy;

  always_comb begin
    // A killed item no longer occupies its slot, so it frees the stage
    // for the upstream item within the same cycle.
    live = valid_q & ~KillMask;

    // A stage can load when it is empty or its occupant moves on; this
    // ripples back from the output, which is what squeezes out bubbles.
    rdy = '0;
    rdy[DEPTH-1] = !live[DEPTH-1] | OutReady;
    for (int i = DEPTH-2; i >= 0; i--) begin
      rdy[i] = !live[i] | rdy[i+1];
    end

    valid_d = valid_q;
    data_d  = data_q;
    if (Flush) begin
      valid_d = '0;
    end else begin
      if (rdy[0]) begin
        valid_d[0] = InValid;
        if (InValid) begin
          data_d[0] = InData;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          valid_d[i] = live[i-1];
          // Data only moves with a live item; a bubble leaves the old word.
          if (live[i-1]) begin
            data_d[i] = data_q[i-1];
          end
        end
      end
    end

    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OCC_W'(valid_d[i]);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  // Gated by Rst so nothing is offered acceptance while reset is held.
  assign InReady   = Rst & rdy[0] & !Flush;
  assign OutValid  = live[DEPTH-1];
  assign OutData   = data_q[DEPTH-1];
  assign Occupancy = occ_q;

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    // Saturates rather than wrapping; Flush intentionally leaves it alone.
    if (live[DEPTH-1] && !OutReady && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
`else
  assign StallCnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Purpose: self-checking bench for pipe_stage_chain (DEPTH=4, WIDTH=32, CNT_W=4).
// Latency: directed scenarios plus randomized traffic against a slot-level item model.
// Backpressure: OutReady is driven both directed and randomly.

module tb_pipe_stage_chain;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int OCC_W = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             flush;
  logic [DEPTH-1:0] kill;
  logic [OCC_W-1:0] occ;
  logic [CNT_W-1:0] stall_cnt;

  int n_pass  = 0;
  int n_total = 0;

  pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .Clk(clk), .Rst(rst_n),
    .InValid(in_valid), .InData(in_data), .InReady(in_ready),
    .OutValid(out_valid), .OutData(out_data), .OutReady(out_ready),
    .Flush(flush), .KillMask(kill),
    .Occupancy(occ), .StallCnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Item-level model: each slot either holds an item or is empty. Per edge,
  // killed items vanish, the front item leaves if downstream takes it, every
  // item steps forward by one if the slot ahead is free, and a new item
  // enters an empty first slot.
  bit               m_vld [DEPTH];
  logic [WIDTH-1:0] m_dat [DEPTH];
  int               m_stall;

  function automatic void model_reset();
    for (int p = 0; p < DEPTH; p++) m_vld[p] = 1'b0;
    m_stall = 0;
  endfunction

  function automatic void model_edge();
    int cap = (1 << CNT_W) - 1;
    if (m_vld[DEPTH-1] && !kill[DEPTH-1] && !out_ready && m_stall < cap) m_stall++;
    if (flush) begin
      for (int p = 0; p < DEPTH; p++) m_vld[p] = 1'b0;
      return;
    end
    for (int p = 0; p < DEPTH; p++) if (kill[p]) m_vld[p] = 1'b0;
    if (m_vld[DEPTH-1] && out_ready) m_vld[DEPTH-1] = 1'b0;
    for (int p = DEPTH-2; p >= 0; p--) begin
      if (m_vld[p] && !m_vld[p+1]) begin
        m_vld[p+1] = 1'b1;
        m_dat[p+1] = m_dat[p];
        m_vld[p]   = 1'b0;
      end
    end
    if (!m_vld[0] && in_valid) begin
      m_vld[0] = 1'b1;
      m_dat[0] = in_data;
    end
  endfunction

  function automatic bit exp_out_valid();
    return m_vld[DEPTH-1] && !kill[DEPTH-1];
  endfunction

  // Input is taken when any slot is (or becomes) free, unless flushing.
  function automatic bit exp_in_ready();
    bit free = out_ready;
    for (int p = 0; p < DEPTH; p++) if (!(m_vld[p] && !kill[p])) free = 1'b1;
    return free && !flush && rst_n;
  endfunction

  function automatic int exp_occ();
    int n = 0;
    for (int p = 0; p < DEPTH; p++) n += int'(m_vld[p]);
    return n;
  endfunction

  function automatic int exp_stall();
`ifdef PIPE_STALL_CNT_EN
    return m_stall;
`else
    return 0;
`endif
  endfunction

  task automatic set_in(input bit v, input logic [WIDTH-1:0] d, input bit ordy,
                        input bit fl, input logic [DEPTH-1:0] km);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    kill      = km;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic fill(input logic [WIDTH-1:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      set_in(1'b1, base + WIDTH'(k), 1'b0, 1'b0, '0);
      mid();
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1'b1, 32'h5A, 1'b1, 1'b0, '0);
    model_reset();
    #3;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b want 0", in_ready); else n_pass++;
    n_total++; if (occ !== '0) $display("FAIL reset_occ: got %0d want 0", occ); else n_pass++;
    n_total++; if (stall_cnt !== '0) $display("FAIL reset_stall: got %0d want 0", stall_cnt); else n_pass++;
    n_total++; if (out_data !== '0) $display("FAIL reset_out_data: got %0h want 0", out_data); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (occ !== '0) $display("FAIL reset_hold_occ: got %0d want 0", occ); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b0, '0, 1'b1, 1'b0, '0);
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %0b want 1", in_ready); else n_pass++;
    tick();
  endtask

  task automatic test_streaming();
    logic [WIDTH-1:0] pushes [3];
    int peak = 0;
    bit exp_v;
    pushes[0] = 32'h11; pushes[1] = 32'h22; pushes[2] = 32'h33;
    for (int k = 0; k <= 8; k++) begin
      set_in(k < 3, (k < 3) ? pushes[k] : '0, 1'b1, 1'b0, '0);
      mid();
      if (int'(occ) > peak) peak = int'(occ);
      exp_v = (k >= 4 && k <= 6);
      n_total++; if (out_valid !== exp_v) $display("FAIL stream_valid_after_edge%0d: got %0b want %0b", k, out_valid, exp_v); else n_pass++;
      if (exp_v) begin
        n_total++; if (out_data !== pushes[k-4]) $display("FAIL stream_data_after_edge%0d: got %0h want %0h", k, out_data, pushes[k-4]); else n_pass++;
      end
      if (k < 3) begin
        n_total++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready%0d: got %0b want 1", k, in_ready); else n_pass++;
      end
      tick();
    end
    n_total++; if (peak != 3) $display("FAIL stream_peak_occ: got %0d want 3", peak); else n_pass++;
  endtask

  task automatic test_backpressure();
    fill(32'hA0, 4);
    for (int c = 0; c < 5; c++) begin
      set_in(1'b1, 32'hEE, 1'b0, 1'b0, '0);
      mid();
      n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready%0d: got %0b want 0", c, in_ready); else n_pass++;
      n_total++; if (out_data !== 32'hA0) $display("FAIL bp_out_data%0d: got %0h want a0", c, out_data); else n_pass++;
      n_total++; if (occ !== OCC_W'(4)) $display("FAIL bp_occ%0d: got %0d want 4", c, occ); else n_pass++;
      tick();
    end
    set_in(1'b0, '0, 1'b1, 1'b0, '0);
    for (int j = 0; j < 4; j++) begin
      mid();
      if (j == 0) begin
`ifdef PIPE_STALL_CNT_EN
        n_total++; if (stall_cnt !== CNT_W'(5)) $display("FAIL bp_stall_cnt: got %0d want 5", stall_cnt); else n_pass++;
`else
        n_total++; if (stall_cnt !== '0) $display("FAIL bp_stall_cnt: got %0d want 0", stall_cnt); else n_pass++;
`endif
      end
      n_total++; if (out_valid !== 1'b1 || out_data !== 32'hA0 + WIDTH'(j))
        $display("FAIL bp_drain%0d: got v=%0b d=%0h want v=1 d=%0h", j, out_valid, out_data, 32'hA0 + j); else n_pass++;
      tick();
    end
    mid();
    n_total++; if (out_valid !== 1'b0 || occ !== '0) $display("FAIL bp_empty: got v=%0b occ=%0d want 0/0", out_valid, occ); else n_pass++;
    tick();
  endtask

  task automatic test_bubble_collapse();
    // Edges 1..4 with OutReady=0: push, idle, push, idle -> stages 3..0 = {1,0,1,0}.
    for (int k = 0; k < 4; k++) begin
      set_in(k == 0 || k == 2, (k == 0) ? 32'hB0 : 32'hB1, 1'b0, 1'b0, '0);
      mid();
      n_total++; if (in_ready !== 1'b1) $display("FAIL bub_fill_in_ready%0d: got %0b want 1", k, in_ready); else n_pass++;
      tick();
    end
    set_in(1'b0, '0, 1'b0, 1'b0, '0);
    mid();
    n_total++; if (occ !== OCC_W'(2) || out_data !== 32'hB0 || in_ready !== 1'b1)
      $display("FAIL bub_pattern: got occ=%0d d=%0h rdy=%0b want 2/b0/1", occ, out_data, in_ready); else n_pass++;
    tick();
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, (k == 0) ? 32'hB2 : (k == 1) ? 32'hB3 : 32'hEE, 1'b0, 1'b0, '0);
      mid();
      n_total++; if (occ !== OCC_W'(2 + k)) $display("FAIL bub_occ%0d: got %0d want %0d", k, occ, 2 + k); else n_pass++;
      n_total++; if (in_ready !== (k < 2)) $display("FAIL bub_in_ready%0d: got %0b want %0b", k, in_ready, k < 2); else n_pass++;
      tick();
    end
    set_in(1'b0, '0, 1'b1, 1'b0, '0);
    for (int j = 0; j < 4; j++) begin
      mid();
      n_total++; if (out_valid !== 1'b1 || out_data !== 32'hB0 + WIDTH'(j))
        $display("FAIL bub_order%0d: got v=%0b d=%0h want v=1 d=%0h", j, out_valid, out_data, 32'hB0 + j); else n_pass++;
      tick();
    end
    mid();
    n_total++; if (out_valid !== 1'b0) $display("FAIL bub_empty: got %0b want 0", out_valid); else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    fill(32'hC1, 3);
    set_in(1'b1, 32'hFF, 1'b0, 1'b1, '0);
    mid();
    n_total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %0b want 0", in_ready); else n_pass++;
    tick();
    set_in(1'b0, '0, 1'b1, 1'b0, '0);
    mid();
    n_total++; if (occ !== '0 || out_valid !== 1'b0) $display("FAIL flush_empty: got occ=%0d v=%0b want 0/0", occ, out_valid); else n_pass++;
    n_total++; if (int'(stall_cnt) != exp_stall()) $display("FAIL flush_stall_kept: got %0d want %0d", stall_cnt, exp_stall()); else n_pass++;
    tick();
    for (int c = 0; c < 5; c++) begin
      mid();
      n_total++; if (out_valid !== 1'b0) $display("FAIL flush_no_emit%0d: got v=%0b d=%0h want v=0", c, out_valid, out_data); else n_pass++;
      tick();
    end
  endtask

  task automatic test_kill();
    set_in(1'b1, 32'h02, 1'b0, 1'b0, '0); mid(); tick();
    set_in(1'b1, 32'h01, 1'b0, 1'b0, '0); mid(); tick();
    set_in(1'b0, '0, 1'b0, 1'b0, '0);     mid(); tick();
    set_in(1'b0, '0, 1'b1, 1'b0, 4'b0100);
    mid();
    n_total++; if (out_valid !== 1'b0 || occ !== OCC_W'(2)) $display("FAIL kill_pre: got v=%0b occ=%0d want 0/2", out_valid, occ); else n_pass++;
    tick();
    set_in(1'b0, '0, 1'b1, 1'b0, '0);
    mid();
    n_total++; if (out_valid !== 1'b0 || occ !== OCC_W'(1)) $display("FAIL kill_post: got v=%0b occ=%0d want 0/1", out_valid, occ); else n_pass++;
    tick();
    mid();
    n_total++; if (out_valid !== 1'b1 || out_data !== 32'h01) $display("FAIL kill_survivor: got v=%0b d=%0h want 1/01", out_valid, out_data); else n_pass++;
    tick();
    mid();
    n_total++; if (out_valid !== 1'b0 || occ !== '0) $display("FAIL kill_drained: got v=%0b occ=%0d want 0/0", out_valid, occ); else n_pass++;
    tick();
    // Killing the stalled head frees the slot so the full chain shifts.
    fill(32'hD0, 4);
    set_in(1'b1, 32'hD4, 1'b0, 1'b0, 4'b1000);
    mid();
    n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || occ !== OCC_W'(4))
      $display("FAIL kill_head: got rdy=%0b v=%0b occ=%0d want 1/0/4", in_ready, out_valid, occ); else n_pass++;
    tick();
    set_in(1'b0, '0, 1'b1, 1'b0, '0);
    for (int j = 0; j < 4; j++) begin
      mid();
      n_total++; if (out_valid !== 1'b1 || out_data !== 32'hD1 + WIDTH'(j))
        $display("FAIL kill_shift%0d: got v=%0b d=%0h want v=1 d=%0h", j, out_valid, out_data, 32'hD1 + j); else n_pass++;
      tick();
    end
  endtask

  task automatic test_stall_sat();
    fill(32'hF0, 4);
    set_in(1'b0, '0, 1'b0, 1'b0, '0);
    for (int c = 0; c < 20; c++) begin
      mid();
      tick();
    end
    mid();
`ifdef PIPE_STALL_CNT_EN
    n_total++; if (stall_cnt !== '1) $display("FAIL stall_saturate: got %0d want 15", stall_cnt); else n_pass++;
`else
    n_total++; if (stall_cnt !== '0) $display("FAIL stall_saturate: got %0d want 0", stall_cnt); else n_pass++;
`endif
    n_total++; if (out_data !== 32'hF0) $display("FAIL stall_hold_data: got %0h want f0", out_data); else n_pass++;
    tick();
    set_in(1'b0, '0, 1'b1, 1'b0, '0);
    for (int j = 0; j < 4; j++) begin
      mid();
      tick();
    end
  endtask

  task automatic test_async_reset();
    fill(32'hE0, 4);
    set_in(1'b1, 32'hE9, 1'b0, 1'b0, '0);
    mid();
    n_total++; if (occ !== OCC_W'(4) || in_ready !== 1'b0) $display("FAIL arst_pre: got occ=%0d rdy=%0b want 4/0", occ, in_ready); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL arst_out_valid: got %0b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL arst_in_ready: got %0b want 0", in_ready); else n_pass++;
    n_total++; if (occ !== '0) $display("FAIL arst_occ: got %0d want 0", occ); else n_pass++;
    n_total++; if (stall_cnt !== '0) $display("FAIL arst_stall: got %0d want 0", stall_cnt); else n_pass++;
    model_reset();
    #1 rst_n = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL arst_release_rdy: got %0b want 1", in_ready); else n_pass++;
    tick();
    set_in(1'b0, '0, 1'b1, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      mid();
      n_total++; if (out_valid !== (k == 3)) $display("FAIL arst_refill%0d: got v=%0b want %0b", k, out_valid, k == 3); else n_pass++;
      if (k == 3) begin
        n_total++; if (out_data !== 32'hE9) $display("FAIL arst_refill_data: got %0h want e9", out_data); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [DEPTH-1:0] km;
    bit ev;
    for (int n = 0; n < 600; n++) begin
      km = '0;
      for (int b = 0; b < DEPTH; b++) km[b] = ($urandom_range(0, 11) == 0);
      set_in(1'($urandom_range(0, 1)), WIDTH'($urandom), ($urandom_range(0, 9) < 7),
             ($urandom_range(0, 24) == 0), km);
      mid();
      ev = exp_out_valid();
      n_total++; if (out_valid !== ev) $display("FAIL rnd_valid@%0d: got %0b want %0b", n, out_valid, ev); else n_pass++;
      if (ev) begin
        n_total++; if (out_data !== m_dat[DEPTH-1]) $display("FAIL rnd_data@%0d: got %0h want %0h", n, out_data, m_dat[DEPTH-1]); else n_pass++;
      end
      n_total++; if (in_ready !== exp_in_ready()) $display("FAIL rnd_in_ready@%0d: got %0b want %0b", n, in_ready, exp_in_ready()); else n_pass++;
      n_total++; if (int'(occ) != exp_occ()) $display("FAIL rnd_occ@%0d: got %0d want %0d", n, occ, exp_occ()); else n_pass++;
      n_total++; if (int'(stall_cnt) != exp_stall()) $display("FAIL rnd_stall@%0d: got %0d want %0d", n, stall_cnt, exp_stall()); else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble_collapse();
    test_flush();
    test_kill();
    test_stall_sat();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
